sos_sample_ctrl: RTL

Sample-side controller for the biquad (`sos`) filter. It accepts samples from the source, launches one filter run per sample with `sample_trig`, and collects the result on `filter_done`. It then serialises that result to the DAC as an I2S-style stereo frame, mono duplicated to both slots. The block sits between the ADC/sample source and the DAC, on the far side of the filter's trigger/done handshake.

---
 rtl/sos_sample_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sos_sample_ctrl.sv
// sos_sample_ctrl: biquad sample controller (trigger/done handshake) with I2S-style mono-to-stereo DAC serialiser.
// Optional WAIT timeout is built in when the macro SOS_CTRL_TIMEOUT_EN is defined; otherwise timeout_err is tied low.
module sos_sample_ctrl #(
   parameter int K       = 24,
   parameter int CLK_DIV = 4,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [K-1:0] adc_data,
   input  logic         adc_valid,
   output logic [K-1:0] audio_in,
   output logic         sample_trig,
   input  logic         filter_done,
   input  logic [K-1:0] audio_out,
   output logic         sclk,
   output logic         lrclk,
   output logic         sdata,
   output logic         busy,
   output logic         overrun,
   output logic         timeout_err
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   typedef enum logic [1:0] {IDLE, TRIG, WAIT, CAPT} state_t;
   state_t        state_q, state_d;
   logic [K-1:0]  audio_in_q, audio_in_d, hold_q, hold_d, frame_q, frame_d;
   logic          pend_q, pend_d, overrun_q, overrun_d;
   logic [DW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d;
   logic [5:0]    bit_q, bit_d;
   logic          tc, fall, load, capt;
   logic [4:0]    slot;
   logic [K-1:0]  shifted;
   if (K < 1 || K > 31) begin : g_bad_k
      $error("sos_sample_ctrl: K must be in 1..31");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("sos_sample_ctrl: CLK_DIV must be >= 1");
   end
   if (TIMEOUT < 4) begin : g_bad_tmo
      $error("sos_sample_ctrl: TIMEOUT must be >= 4");
   end
`ifdef SOS_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_err_q, tmo_err_d;
`endif
   // Control FSM: accept sample, trigger filter, wait for done, capture into holding register.
   always_comb begin
      state_d    = state_q;
      audio_in_d = audio_in_q;
      hold_d     = hold_q;
      capt       = 1'b0;
`ifdef SOS_CTRL_TIMEOUT_EN
      tmo_cnt_d  = '0;
      tmo_err_d  = tmo_err_q;
`endif
      case (state_q)
         IDLE: if (adc_valid) begin
            audio_in_d = adc_data;
            state_d    = TRIG;
         end
         TRIG: state_d = WAIT;
         WAIT: if (filter_done) begin
            hold_d  = audio_out;
            capt    = 1'b1;
            state_d = CAPT;
         end
`ifdef SOS_CTRL_TIMEOUT_EN
         else if (tmo_cnt_q == TW'(TIMEOUT - 2)) begin
            tmo_err_d = 1'b1;
            state_d   = IDLE;
         end else tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
         default: state_d = IDLE;
      endcase
      pend_d    = capt | (pend_q & ~load);
      overrun_d = overrun_q | (adc_valid && state_q != IDLE) | (capt & pend_q & ~load);
   end
   // Serialiser timing: clock divider, sclk toggle, bit index and frame load at the 63->0 wrap.
   always_comb begin
      tc      = div_q == DW'(CLK_DIV - 1);
      div_d   = tc ? '0 : div_q + 1'b1;
      sclk_d  = sclk_q ^ tc;
      fall    = tc & sclk_q;
      bit_d   = fall ? bit_q + 6'd1 : bit_q;
      load    = fall && bit_q == 6'd63;
      frame_d = (load && pend_q) ? hold_q : frame_q;
   end
   // Serial data: slot bit 0 is the one-bit delay, slot bits 1..K carry the sample MSB first.
   always_comb begin
      slot    = bit_q[4:0];
      shifted = frame_q << (slot - 5'd1);
      sdata   = slot != 5'd0 && slot <= 5'(K) && shifted[K-1];
   end
   // State registers, cleared asynchronously so a reset aborts runs and frames at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         audio_in_q <= '0;
         hold_q     <= '0;
         frame_q    <= '0;
         pend_q     <= 1'b0;
         overrun_q  <= 1'b0;
         div_q      <= '0;
         sclk_q     <= 1'b0;
         bit_q      <= '0;
      end else begin
         state_q    <= state_d;
         audio_in_q <= audio_in_d;
         hold_q     <= hold_d;
         frame_q    <= frame_d;
         pend_q     <= pend_d;
         overrun_q  <= overrun_d;
         div_q      <= div_d;
         sclk_q     <= sclk_d;
         bit_q      <= bit_d;
      end
   end
`ifdef SOS_CTRL_TIMEOUT_EN
   // Timeout counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end
   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif
   assign audio_in    = audio_in_q;
   assign sample_trig = state_q == TRIG;
   assign busy        = state_q != IDLE;
   assign sclk        = sclk_q;
   assign lrclk       = bit_q[5];
   assign overrun     = overrun_q;
endmodule
